// File: rtl/comb_sweep_checker_pkg.sv
// Shared types and constants for the combinational truth-table sweeper.
package comb_sweep_pkg;

   typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CAPTURE, DONE} state_t;

   localparam int                SIG_W    = 16;
   localparam logic [SIG_W-1:0]  SIG_POLY = 16'h1021;

endpackage

// File: rtl/comb_sweep_checker_if.sv
// Bus between the sweeper and its lab harness: DUT stimulus/response, control and readback.
interface comb_sweep_checker_if
   import comb_sweep_pkg::*;
#(
   parameter int N_IN  = 5,
   parameter int N_OUT = 1
);
   logic              i_start;
   logic              i_abort;
   logic [N_IN-1:0]   o_vec_out;
   logic [N_OUT-1:0]  i_resp_in;
   logic              o_busy;
   logic              o_done;
   logic [N_IN:0]     o_hit_cnt;
   logic [N_IN-1:0]   i_rd_addr;
   logic [N_OUT-1:0]  o_rd_data;
   logic [SIG_W-1:0]  o_sig_out;

   modport master (
      input  i_start, i_abort, i_resp_in, i_rd_addr,
      output o_vec_out, o_busy, o_done, o_hit_cnt, o_rd_data, o_sig_out
   );

   modport slave (
      output i_start, i_abort, i_resp_in, i_rd_addr,
      input  o_vec_out, o_busy, o_done, o_hit_cnt, o_rd_data, o_sig_out
   );
endinterface

// File: rtl/comb_sweep_checker_misr.sv
// 16-bit MISR (x^16+x^12+x^5+1) folding one captured response per enabled cycle.
module sweep_misr
   import comb_sweep_pkg::*;
#(
   parameter int DIN_W = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [DIN_W-1:0]  i_din,
   output logic [SIG_W-1:0]  o_sig
);
   logic [SIG_W-1:0] r_sig;
   logic [SIG_W-1:0] w_din_ext;
   logic [SIG_W-1:0] w_fb;

   assign w_din_ext = {{(SIG_W-DIN_W){1'b0}}, i_din};
   assign w_fb      = r_sig[SIG_W-1] ? SIG_POLY : '0;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)
         r_sig <= '0;
      else if (i_en)
         r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ w_din_ext;
   end

   assign o_sig = r_sig;
endmodule

// File: rtl/comb_sweep_checker.sv
// Sweeps all 2^N_IN vectors into a combinational DUT, captures a truth table and counts hits.
// Optional response signature enabled by macro COMB_SWEEP_MISR_EN.
module comb_sweep_checker
   import comb_sweep_pkg::*;
#(
   parameter int N_IN   = 5,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   comb_sweep_checker_if.master bus
);
   localparam int             DEPTH     = 1 << N_IN;
   localparam logic [N_IN:0]  LAST_IDX  = (N_IN+1)'(DEPTH-1);
   localparam logic [3:0]     WAIT_INIT = 4'((SETTLE > 0) ? SETTLE-1 : 0);

   state_t            r_state, w_next;
   logic [N_IN:0]     r_idx;
   logic [N_IN-1:0]   r_vec;
   logic [3:0]        r_wait;
   logic              r_busy;
   logic              r_done;
   logic [N_IN:0]     r_hit;
   logic [N_OUT-1:0]  r_table [DEPTH];

   logic              w_abort;
   logic              w_start_ok;
   logic              w_capture;
   logic [SIG_W-1:0]  w_sig;

   assign w_abort    = bus.i_abort && (r_state != IDLE);
   assign w_start_ok = (r_state == IDLE) && bus.i_start && !bus.i_abort;
   assign w_capture  = (r_state == CAPTURE) && !bus.i_abort;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_start_ok) w_next = DRIVE;
         DRIVE:   w_next = (SETTLE > 0) ? WAIT : CAPTURE;
         WAIT:    if (r_wait == 4'd0) w_next = CAPTURE;
         CAPTURE: w_next = (r_idx == LAST_IDX) ? DONE : DRIVE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (w_abort)
         w_next = IDLE;
   end

   // idx is one bit wider than the vector so the last-vector test never aliases to 0
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx  <= '0;
         r_vec  <= '0;
         r_wait <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_hit  <= '0;
      end else begin
         r_done <= (r_state == DONE) && !bus.i_abort;
         if (w_abort) begin
            r_busy <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE: if (w_start_ok) begin
                  r_idx  <= '0;
                  r_hit  <= '0;
                  r_busy <= 1'b1;
               end
               DRIVE: begin
                  r_vec  <= r_idx[N_IN-1:0];
                  r_wait <= WAIT_INIT;
               end
               WAIT: if (r_wait != 4'd0) r_wait <= r_wait - 4'd1;
               CAPTURE: begin
                  if (|bus.i_resp_in)     r_hit <= r_hit + (N_IN+1)'(1);
                  if (r_idx != LAST_IDX)  r_idx <= r_idx + (N_IN+1)'(1);
               end
               DONE: r_busy <= 1'b0;
               default: ;
            endcase
         end
      end
   end

   // Table is deliberately not reset; it is only meaningful after a completed sweep
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_capture)
         r_table[r_idx[N_IN-1:0]] <= bus.i_resp_in;
   end

`ifdef COMB_SWEEP_MISR_EN
   sweep_misr #(.DIN_W(N_OUT)) u_misr (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_start_ok),
      .i_en  (w_capture),
      .i_din (bus.i_resp_in),
      .o_sig (w_sig)
   );
`else
   assign w_sig = '0;
`endif

   assign bus.o_vec_out = r_vec;
   assign bus.o_busy    = r_busy;
   assign bus.o_done    = r_done;
   assign bus.o_hit_cnt = r_hit;
   assign bus.o_rd_data = r_table[bus.i_rd_addr];
   assign bus.o_sig_out = w_sig;
endmodule
